// File: rtl/falafel_mem_responder.sv
// falafel_mem_responder: word-addressed heap memory with fixed-latency, in-order, credit-limited responses
module falafel_mem_responder #(
    parameter int                DATA_W          = 64,
    parameter int                DEPTH_WORDS     = 1024,
    parameter logic [DATA_W-1:0] BASE_ADDR       = '0,
    parameter int                LATENCY         = 2,
    parameter int                MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
    output logic [DATA_W-1:0] mem_rsp_data_o,
    output logic              err_o
);
    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AW    = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_W-1:0] r_mem  [DEPTH_WORDS];
    logic [DATA_W-1:0] r_fifo [2**AW];
    logic [AW-1:0]     r_wp, r_rp;
    logic [CW-1:0]     r_fcnt, r_out;
    logic              r_err;
    logic              w_acc, w_pop, w_inr, w_push;
    logic [DATA_W-1:0] w_off, w_rsp, w_pdata;
    logic [IDX_W-1:0]  w_idx;

    assign mem_req_rdy_o  = r_out < CW'(MAX_OUTSTANDING);
    assign w_acc          = mem_req_val_i && mem_req_rdy_o;
    assign mem_rsp_val_o  = r_fcnt != '0;
    assign w_pop          = mem_rsp_val_o && mem_rsp_rdy_i;
    assign w_off          = mem_req_addr_i - BASE_ADDR;
    assign w_inr          = mem_req_addr_i >= BASE_ADDR && (w_off >> OFF) < DATA_W'(DEPTH_WORDS);
    assign w_idx          = w_off[OFF +: IDX_W];
    assign w_rsp          = mem_req_is_write_i ? mem_req_data_i : (w_inr ? r_mem[w_idx] : '0);
    assign mem_rsp_data_o = mem_rsp_val_o ? r_fifo[r_rp] : '0;
    assign err_o          = r_err;

    always_ff @(posedge clk_i)
        if (!rst_i && w_acc && mem_req_is_write_i && w_inr) r_mem[w_idx] <= mem_req_data_i;

    // Response payload is captured at accept and delayed so it lands in the FIFO LATENCY-1 edges later
    generate
        if (LATENCY > 1) begin : g_dly
            logic              r_v [LATENCY-1];
            logic [DATA_W-1:0] r_d [LATENCY-1];
            always_ff @(posedge clk_i) begin
                r_v[0] <= !rst_i && w_acc;
                r_d[0] <= w_rsp;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    r_v[k] <= !rst_i && r_v[k-1];
                    r_d[k] <= r_d[k-1];
                end
            end
            assign w_push  = r_v[LATENCY-2];
            assign w_pdata = r_d[LATENCY-2];
        end else begin : g_nodly
            assign w_push  = w_acc;
            assign w_pdata = w_rsp;
        end
    endgenerate

    // Credits cover the delay line plus FIFO, so the FIFO cannot overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
            r_out  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp] <= w_pdata;
                r_wp         <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
            r_out  <= r_out + CW'(w_acc) - CW'(w_pop);
            if (w_acc && !w_inr) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_falafel_mem_responder.sv
// tb_falafel_mem_responder: directed cycle table plus randomized traffic against a queue-based reference model
module tb_falafel_mem_responder;
    localparam int L  = 2;
    localparam int MO = 4;
    localparam int DW = 1024;

    logic        clk_i = 0, rst_i = 1, mem_req_val_i = 0, mem_req_is_write_i = 0, mem_rsp_rdy_i = 0;
    logic [63:0] mem_req_addr_i = '0, mem_req_data_i = '0;
    logic        mem_req_rdy_o, mem_rsp_val_o, err_o;
    logic [63:0] mem_rsp_data_o;

    falafel_mem_responder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_val_i(mem_req_val_i), .mem_req_rdy_o(mem_req_rdy_o),
        .mem_req_is_write_i(mem_req_is_write_i), .mem_req_addr_i(mem_req_addr_i),
        .mem_req_data_i(mem_req_data_i), .mem_rsp_val_o(mem_rsp_val_o),
        .mem_rsp_rdy_i(mem_rsp_rdy_i), .mem_rsp_data_o(mem_rsp_data_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          rst, v, w;
        logic [63:0] a, d;
        bit          rr, e_rdy, e_val;
        logic [63:0] e_data;
        bit          e_err;
    } vec_t;
    typedef struct { logic [63:0] data; int due; } rsp_t;

    vec_t        tbl[$];
    rsp_t        q[$];
    logic [63:0] mm [logic [63:0]];
    bit          m_err;
    int          cyc, passed, total, acc_cnt;
    bit          s_rdy, s_val, s_err;
    logic [63:0] s_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic add(input bit rst, v, w, input logic [63:0] a, d, input bit rr,
                       input bit e_rdy, e_val, input logic [63:0] e_data, input bit e_err);
        tbl.push_back('{rst, v, w, a, d, rr, e_rdy, e_val, e_data, e_err});
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, then advance the model across the edge
    task automatic step(input bit rst, v, w, input logic [63:0] a, d, input bit rr, input string tag);
        bit          m_rdy, m_val, inr;
        logic [63:0] m_data, rd;
        rst_i = rst; mem_req_val_i = v; mem_req_is_write_i = w;
        mem_req_addr_i = a; mem_req_data_i = d; mem_rsp_rdy_i = rr;
        @(negedge clk_i);
        m_rdy  = q.size() < MO;
        m_val  = q.size() > 0 && q[0].due <= cyc;
        m_data = m_val ? q[0].data : 64'd0;
        s_rdy = mem_req_rdy_o; s_val = mem_rsp_val_o; s_data = mem_rsp_data_o; s_err = err_o;
        chk({tag, " model rdy"}, {63'd0, s_rdy}, {63'd0, m_rdy});
        chk({tag, " model val"}, {63'd0, s_val}, {63'd0, m_val});
        chk({tag, " model data"}, s_data, m_data);
        chk({tag, " model err"}, {63'd0, s_err}, {63'd0, m_err});
        @(posedge clk_i);
        if (rst) begin
            q.delete();
            m_err = 0;
        end else begin
            if (m_val && rr) void'(q.pop_front());
            if (v && m_rdy) begin
                acc_cnt++;
                inr = a < 64'(DW * 8);
                rd  = (inr && mm.exists(a >> 3)) ? mm[a >> 3] : 64'd0;
                if (w && inr) mm[a >> 3] = d;
                if (!inr) m_err = 1;
                q.push_back('{w ? d : rd, cyc + L});
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        logic [63:0] a;
        // rst v w  addr          data           rr | rdy val data          err
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 0, 64'h0,        0);
        add(0, 1, 1, 64'h40,   64'hDEADBEEF, 1,   1, 0, 64'h0,        0);
        add(0, 1, 0, 64'h40,   64'h0,        1,   1, 0, 64'h0,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'hDEADBEEF, 0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'hDEADBEEF, 0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 0, 64'h0,        0);
        add(0, 1, 1, 64'h0,    64'd1,        1,   1, 0, 64'h0,        0);
        add(0, 1, 1, 64'h8,    64'd2,        1,   1, 0, 64'h0,        0);
        add(0, 1, 1, 64'h10,   64'd3,        1,   1, 1, 64'd1,        0);
        add(0, 1, 1, 64'h18,   64'd4,        1,   1, 1, 64'd2,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'd3,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'd4,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 0, 64'h0,        0);
        add(0, 1, 0, 64'h0,    64'h0,        0,   1, 0, 64'h0,        0);
        add(0, 1, 0, 64'h8,    64'h0,        0,   1, 0, 64'h0,        0);
        add(0, 1, 0, 64'h10,   64'h0,        0,   1, 1, 64'd1,        0);
        add(0, 1, 0, 64'h18,   64'h0,        0,   1, 1, 64'd1,        0);
        add(0, 1, 0, 64'h0,    64'h0,        0,   0, 1, 64'd1,        0);
        add(0, 1, 0, 64'h0,    64'h0,        0,   0, 1, 64'd1,        0);
        add(0, 1, 0, 64'h0,    64'h0,        1,   0, 1, 64'd1,        0);
        add(0, 1, 0, 64'h0,    64'h0,        1,   1, 1, 64'd2,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'd3,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'd4,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'd1,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 0, 64'h0,        0);
        add(0, 1, 1, 64'h0,    64'd7,        1,   1, 0, 64'h0,        0);
        add(0, 1, 0, 64'h3,    64'h0,        1,   1, 0, 64'h0,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'd7,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'd7,        0);
        add(0, 1, 1, 64'h2000, 64'd5,        1,   1, 0, 64'h0,        0);
        add(0, 1, 0, 64'h2000, 64'h0,        1,   1, 0, 64'h0,        1);
        add(0, 1, 0, 64'h0,    64'h0,        1,   1, 1, 64'd5,        1);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'h0,        1);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'd7,        1);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 0, 64'h0,        1);
        add(0, 1, 1, 64'h20,   64'hAB,       0,   1, 0, 64'h0,        1);
        add(0, 1, 0, 64'h20,   64'h0,        0,   1, 0, 64'h0,        1);
        add(0, 1, 0, 64'h0,    64'h0,        0,   1, 1, 64'hAB,       1);
        add(1, 0, 0, 64'h0,    64'h0,        0,   1, 1, 64'hAB,       1);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 0, 64'h0,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 0, 64'h0,        0);
        add(0, 1, 0, 64'h20,   64'h0,        1,   1, 0, 64'h0,        0);
        add(0, 1, 0, 64'h0,    64'h0,        1,   1, 0, 64'h0,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'hAB,       0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 1, 64'd7,        0);
        add(0, 0, 0, 64'h0,    64'h0,        1,   1, 0, 64'h0,        0);

        @(posedge clk_i); #1;
        step(1, 0, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 0, "reset");
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rr, $sformatf("row%0d", i));
            chk($sformatf("row%0d rdy", i), {63'd0, s_rdy}, {63'd0, tbl[i].e_rdy});
            chk($sformatf("row%0d val", i), {63'd0, s_val}, {63'd0, tbl[i].e_val});
            chk($sformatf("row%0d data", i), s_data, tbl[i].e_data);
            chk($sformatf("row%0d err", i), {63'd0, s_err}, {63'd0, tbl[i].e_err});
        end

        // Back-to-back alternating write/read stream with the response side always ready
        acc_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1, i % 2 == 0, 64'h100 + 64'(8 * (i / 2)), 64'hC0DE_0000 + 64'(i), 1, "stream");
            chk("stream rdy high", {63'd0, s_rdy}, 64'd1);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, "stream drain");
        chk("stream accept count", 64'(acc_cnt), 64'd16);

        for (int i = 0; i < 800; i++) begin
            bit r, v;
            r = $urandom_range(99) == 0;
            v = !r && $urandom_range(2) != 0;
            case ($urandom_range(9))
                0:       a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
                1:       a = 64'h2000 + 64'($urandom_range(800));
                default: a = 64'h100 + 64'(8 * $urandom_range(7)) + 64'($urandom_range(7));
            endcase
            step(r, v, 1'($urandom_range(1)), a, {$urandom, $urandom}, $urandom_range(3) != 0, "random");
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, "final drain");
        chk("final idle val", {63'd0, s_val}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
